spi_shift_engine: RTL and testbench

Parametrised SPI data-path shifter: the successor to the single-lane shift-out counter. It loads a word, shifts it out over 1, 2 or 4 lanes with a run-time bit length and bit order, and captures the same number of bits from the input lanes. It signals the last beat and completion. It sits between the SPI controller FSM (which issues loads and shift ticks) and the pad lanes (SDO/SDI, or IO0-IO3 in quad mode).

---
 rtl/spi_shift_engine_if.sv | 36 +++
 rtl/spi_shift_engine.sv | 127 ++++++++++++
 tb/tb_spi_shift_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_if.sv
// Handshake and lane bundle between the SPI controller and the shift engine.
interface spi_shift_engine_if #(
  parameter int SIZE  = 32,
  parameter int LANES = 4
);
  localparam int CW = $clog2(SIZE) + 1;

  logic [SIZE-1:0]  din;
  logic [CW-1:0]    len;
  logic [1:0]       mode;
  logic             lsb_first;
  logic             load_valid;
  logic             load_ready;
  logic             se;
  logic             abort;
  logic [LANES-1:0] sdo;
  logic [LANES-1:0] sdi;
  logic [SIZE-1:0]  dout;
  logic             done;
  logic             lst_cycle;
  logic             err;

  modport master (
    output din, len, mode, lsb_first,
    output load_valid, se, abort, sdi,
    input  load_ready, sdo, dout,
    input  done, lst_cycle, err
  );

  modport slave (
    input  din, len, mode, lsb_first,
    input  load_valid, se, abort, sdi,
    output load_ready, sdo, dout,
    output done, lst_cycle, err
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Multi-lane SPI shifter: loads a word, shifts it out over 1/2/4 lanes
// with run-time length and bit order, capturing the same bits from sdi.
module spi_shift_engine #(
  parameter int SIZE  = 32,
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst,
  spi_shift_engine_if.slave bus
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] SZ = CW'(SIZE);
  localparam logic [CW-1:0] LW = CW'(LANES);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [SIZE-1:0] sreg, sreg_n;
  logic [SIZE-1:0] dout_q, dout_n;
  logic [SIZE-1:0] shifted, sdi_ext, tx;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   len_q, len_n;
  logic [CW-1:0]   w_cur, w_new;
  logic [1:0]      mode_q, mode_n;
  logic            lsb_q, lsb_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            legal, take;

  // Lane widths kept as counts so they compare directly against cnt/len
  assign w_cur = CW'(1) << mode_q;
  assign w_new = CW'(1) << bus.mode;

  assign legal = (bus.mode != 2'd3) && (w_new <= LW)
              && (bus.len != '0) && (bus.len <= SZ)
              && ((bus.len & (w_new - CW'(1))) == '0);

  assign bus.load_ready = (state != SHIFT) && !bus.abort;
  assign take           = bus.load_valid && bus.load_ready;
  assign bus.lst_cycle  = (state == SHIFT) && (cnt == w_cur);
  assign bus.dout       = dout_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  always_comb begin
    sdi_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < w_cur) sdi_ext[i] = bus.sdi[i];
    end
  end

  assign shifted = lsb_q ? ((sreg >> w_cur) | (sdi_ext << (SZ - w_cur)))
                         : ((sreg << w_cur) | sdi_ext);

  // MSB-first beats come from the top of the register, right-aligned
  assign tx = lsb_q ? sreg : (sreg >> (SZ - w_cur));

  always_comb begin
    bus.sdo = '0;
    if (state == SHIFT) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < w_cur) bus.sdo[i] = tx[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    dout_n  = dout_q;
    cnt_n   = cnt;
    len_n   = len_q;
    mode_n  = mode_q;
    lsb_n   = lsb_q;
    done_n  = done_q;
    err_n   = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end else if (take) begin
      if (legal) begin
        state_n = SHIFT;
        sreg_n  = bus.lsb_first ? bus.din : (bus.din << (SZ - bus.len));
        cnt_n   = bus.len;
        len_n   = bus.len;
        mode_n  = bus.mode;
        lsb_n   = bus.lsb_first;
        done_n  = 1'b0;
      end else begin
        err_n = 1'b1;
      end
    end else if (state == SHIFT && bus.se) begin
      sreg_n = shifted;
      cnt_n  = cnt - w_cur;
      if (cnt == w_cur) begin
        state_n = DONE;
        done_n  = 1'b1;
        dout_n  = lsb_q ? (shifted >> (SZ - len_q))
                        : (shifted & ({SIZE{1'b1}} >> (SZ - len_q)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      dout_q <= '0;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= '0;
      lsb_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      dout_q <= dout_n;
      cnt    <= cnt_n;
      len_q  <= len_n;
      mode_q <= mode_n;
      lsb_q  <= lsb_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine against a beat-level model.
module tb_spi_shift_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   pass  = 0;
  logic [31:0] last_dout = '0;
  logic [3:0]  rx_tab [0:31];

  spi_shift_engine_if #(.SIZE(32), .LANES(4)) bus();

  spi_shift_engine #(.SIZE(32), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a transfer: the w bits sent, right-aligned, first bit highest
  // for MSB-first and lowest for LSB-first.
  function automatic logic [3:0] tx_of(logic [31:0] d, int l, int w,
                                       bit lsb, int k);
    int sh;
    sh = lsb ? k * w : l - (k + 1) * w;
    return 4'((d >> sh) & ((32'd1 << w) - 1));
  endfunction

  task automatic run_xfer(input logic [31:0] d, input int l, input int m,
                          input bit lsb, input int src, input bit gapped,
                          input string nm);
    int          w, nb;
    logic [31:0] exp_rx;
    logic [3:0]  t, b, mask;
    w = 1 << m;
    nb = l / w;
    mask = 4'((1 << w) - 1);
    exp_rx = '0;
    bus.din = d;
    bus.len = 6'(l);
    bus.mode = 2'(m);
    bus.lsb_first = lsb;
    bus.load_valid = 1'b1;
    bus.se = 1'($urandom);
    tick();
    bus.load_valid = 1'b0;
    bus.din = $urandom;
    total++;
    if ({bus.load_ready, bus.done, bus.err} !== 3'b000)
      $display("FAIL %s load: ready/done/err=%b want 000", nm,
               {bus.load_ready, bus.done, bus.err});
    else pass++;
    for (int k = 0; k < nb; k++) begin
      t = tx_of(d, l, w, lsb, k);
      case (src)
        0:       b = t;
        1:       b = rx_tab[k] & mask;
        default: b = 4'($urandom) & mask;
      endcase
      bus.sdi = b | (4'($urandom) & ~mask);
      bus.se = 1'b1;
      #1;
      total++;
      if ({bus.sdo, bus.lst_cycle, bus.done} !== {t, k == nb - 1, 1'b0})
        $display("FAIL %s beat %0d: sdo/lst/done=%h/%b/%b want %h/%b/0",
                 nm, k, bus.sdo, bus.lst_cycle, bus.done, t, k == nb - 1);
      else pass++;
      if (lsb) exp_rx = exp_rx | (32'(b) << (k * w));
      else     exp_rx = (exp_rx << w) | 32'(b);
      tick();
      if (gapped && k < nb - 1) begin
        bus.se = 1'b0;
        bus.sdi = 4'($urandom);
        tick();
        total++;
        if ({bus.sdo, bus.done} !== {tx_of(d, l, w, lsb, k + 1), 1'b0})
          $display("FAIL %s gap %0d: sdo/done=%h/%b want %h/0", nm, k,
                   bus.sdo, bus.done, tx_of(d, l, w, lsb, k + 1));
        else pass++;
      end
    end
    bus.se = 1'b0;
    last_dout = exp_rx;
    total++;
    if ({bus.done, bus.lst_cycle, bus.sdo, bus.load_ready} !== {2'b10, 4'h0, 1'b1})
      $display("FAIL %s end: done/lst/sdo/ready=%b/%b/%h/%b want 1/0/0/1",
               nm, bus.done, bus.lst_cycle, bus.sdo, bus.load_ready);
    else pass++;
    total++;
    if (bus.dout !== exp_rx)
      $display("FAIL %s dout: got %h want %h", nm, bus.dout, exp_rx);
    else pass++;
  endtask

  task automatic test_reset();
    bus.din = '0; bus.len = '0; bus.mode = '0; bus.lsb_first = 1'b0;
    bus.load_valid = 1'b0; bus.se = 1'b0; bus.abort = 1'b0; bus.sdi = '0;
    rst = 1'b1;
    #12;
    total++;
    if ({bus.sdo, bus.dout, bus.done, bus.lst_cycle, bus.err, bus.load_ready}
        !== {4'h0, 32'h0, 4'b0001})
      $display("FAIL reset: sdo=%h dout=%h done=%b lst=%b err=%b ready=%b",
               bus.sdo, bus.dout, bus.done, bus.lst_cycle, bus.err,
               bus.load_ready);
    else pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    int lens [4] = '{6, 0, 33, 4};
    int ms   [4] = '{2, 2, 2, 3};
    for (int i = 0; i < 4; i++) begin
      bus.din = $urandom;
      bus.len = 6'(lens[i]);
      bus.mode = 2'(ms[i]);
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      total++;
      if ({bus.err, bus.load_ready, bus.done, bus.lst_cycle, bus.sdo} !== 8'b1100_0000)
        $display("FAIL illegal %0d: err/ready/done/lst/sdo=%b/%b/%b/%b/%h want 1/1/0/0/0",
                 i, bus.err, bus.load_ready, bus.done, bus.lst_cycle, bus.sdo);
      else pass++;
      tick();
      total++;
      if (bus.err !== 1'b0)
        $display("FAIL illegal %0d pulse: err=%b want 0", i, bus.err);
      else pass++;
    end
  endtask

  task automatic test_abort();
    bus.din = 32'h1234_5678; bus.len = 6'd32; bus.mode = 2'd2;
    bus.lsb_first = 1'b0; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.se = 1'b1;
    bus.sdi = 4'h3;
    repeat (3) tick();
    bus.abort = 1'b1;
    bus.load_valid = 1'b1;
    #1;
    total++;
    if (bus.load_ready !== 1'b0)
      $display("FAIL abort ready: got %b want 0", bus.load_ready);
    else pass++;
    tick();
    bus.abort = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    total++;
    if ({bus.load_ready, bus.done, bus.lst_cycle, bus.sdo} !== 7'b1000_000)
      $display("FAIL abort idle: ready/done/lst/sdo=%b/%b/%b/%h want 1/0/0/0",
               bus.load_ready, bus.done, bus.lst_cycle, bus.sdo);
    else pass++;
    repeat (10) tick();
    total++;
    if ({bus.done, bus.dout} !== {1'b0, last_dout})
      $display("FAIL abort hold: done=%b dout=%h want 0/%h", bus.done,
               bus.dout, last_dout);
    else pass++;
    bus.se = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h0000_00C3, 8, 1, 1'b0, 2, 1'b0, "b2b_first");
    total++;
    if ({bus.done, bus.load_ready} !== 2'b11)
      $display("FAIL b2b pre: done/ready=%b want 11", {bus.done, bus.load_ready});
    else pass++;
    run_xfer(32'hDEAD_BEEF, 16, 2, 1'b1, 2, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    bus.din = 32'hFFFF_FFFF; bus.len = 6'd32; bus.mode = 2'd0;
    bus.lsb_first = 1'b0; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.se = 1'b1;
    bus.sdi = 4'hF;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.sdo, bus.done, bus.dout, bus.lst_cycle, bus.load_ready}
        !== {4'h0, 1'b0, 32'h0, 2'b01})
      $display("FAIL reset_mid: sdo=%h done=%b dout=%h lst=%b ready=%b",
               bus.sdo, bus.done, bus.dout, bus.lst_cycle, bus.load_ready);
    else pass++;
    #2;
    rst = 1'b0;
    last_dout = '0;
    repeat (40) tick();
    total++;
    if ({bus.done, bus.dout} !== 33'h0)
      $display("FAIL reset_mid after: done=%b dout=%h want 0/0",
               bus.done, bus.dout);
    else pass++;
    bus.se = 1'b0;
  endtask

  task automatic test_random();
    int m, w, l;
    for (int n = 0; n < 24; n++) begin
      m = $urandom_range(0, 2);
      w = 1 << m;
      l = w * $urandom_range(1, 32 / w);
      run_xfer($urandom, l, m, 1'($urandom), $urandom_range(0, 2),
               1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    run_xfer(32'h0000_00A5, 8, 0, 1'b0, 0, 1'b0, "single_msb");
    tick();
    for (int i = 0; i < 8; i++) rx_tab[i] = 4'hC;
    run_xfer(32'h1234_5678, 32, 2, 1'b0, 1, 1'b0, "quad_msb");
    rx_tab[0] = 4'h3; rx_tab[1] = 4'h0; rx_tab[2] = 4'h2;
    run_xfer(32'h0000_002D, 6, 1, 1'b1, 1, 1'b0, "dual_lsb");
    run_xfer(32'h0000_00A5, 8, 0, 1'b0, 0, 1'b1, "gapped");
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
